// File: rtl/wb4_fifo_read_master_if.sv
// Wishbone B4 pipelined read-port bundle between a read master and a FIFO
// exposed as a WB4 slave.
//   cyc   master -> slave  bus cycle in progress
//   stb   master -> slave  read strobe
//   stall slave  -> master strobe not accepted this cycle (FIFO empty)
//   ack   slave  -> master read data valid this cycle
//   data  slave  -> master read data
interface wb4_fifo_read_master_if #(
  parameter int P_DATA_MSB = 7
);
  logic              cyc;
  logic              stb;
  logic              stall;
  logic              ack;
  logic [P_DATA_MSB:0] data;

  modport master (
    output cyc,
    output stb,
    input  stall,
    input  ack,
    input  data
  );

  modport slave (
    input  cyc,
    input  stb,
    output stall,
    output ack,
    output data
  );
endinterface

// File: rtl/wb4_fifo_read_master.sv
// Wishbone B4 pipelined read master that drains a FIFO slave port and
// presents the words on a valid/ready stream. Runs in the FIFO read clock
// domain.
// Ports:
//   i_wb4_mclk  clock, all registers on posedge
//   i_wb4_mrst  synchronous active-high reset
//   i_enable    1 = keep draining; 0 = stop strobing and close the cycle
//   wb          WB4 master port (cyc/stb out, stall/ack/data in)
//   o_data      stream data, head of the response buffer (0 when empty)
//   o_valid     stream valid
//   i_ready     stream ready; a word moves on o_valid & i_ready
//   o_level     response buffer occupancy
//   o_timeout   one-cycle pulse when an ack timeout aborts the cycle
module wb4_fifo_read_master #(
  parameter int P_DATA_MSB        = 7,
  parameter int P_MAX_OUTSTANDING = 4,
  parameter int P_BUF_DEPTH       = 4,
  parameter int P_ACK_TIMEOUT     = 255
) (
  input  logic                          i_wb4_mclk,
  input  logic                          i_wb4_mrst,
  input  logic                          i_enable,
  wb4_fifo_read_master_if.master        wb,
  output logic [P_DATA_MSB:0]           o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(P_BUF_DEPTH):0]  o_level,
  output logic                          o_timeout
);

  localparam int AW    = $clog2(P_BUF_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int OUT_W = $clog2(P_MAX_OUTSTANDING + 1);
  localparam int TMO_W = $clog2(P_ACK_TIMEOUT + 1);
  localparam int SUM_W = ((OUT_W > LVL_W) ? OUT_W : LVL_W) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    ABORT  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [OUT_W-1:0]    outstanding;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [LVL_W-1:0]    wr_ptr;
  logic [LVL_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [P_DATA_MSB:0] mem [P_BUF_DEPTH];

  logic             cyc;
  logic             stb;
  logic             in_cycle;
  logic             credit;
  logic             accept;
  logic             ack_ok;
  logic             push;
  logic             pop;
  logic             full;
  logic             tmo_hit;
  logic             drain_done;
  logic [SUM_W-1:0] committed;

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == LVL_W'(P_BUF_DEPTH));
  assign in_cycle  = (state == ACTIVE) || (state == DRAIN);

  // Every accepted strobe reserves a buffer slot, so words in flight plus
  // words held can never exceed the buffer. Uses registered state only, so
  // a pop this cycle frees its slot for the next cycle.
  assign committed = SUM_W'(outstanding) + SUM_W'(level);
  assign credit    = (outstanding < OUT_W'(P_MAX_OUTSTANDING)) &&
                     (committed < SUM_W'(P_BUF_DEPTH));

  assign accept    = stb && !wb.stall;
  // Acks with nothing outstanding, or outside a bus cycle, are stray.
  assign ack_ok    = wb.ack && in_cycle && (outstanding != '0);
  assign push      = ack_ok && !full;
  assign pop       = o_valid && i_ready;

  assign tmo_hit   = in_cycle && (outstanding != '0) && !wb.ack &&
                     (tmo_cnt == TMO_W'(P_ACK_TIMEOUT - 1));
  // An ack landing this cycle on the last outstanding request also closes
  // the cycle.
  assign drain_done = (outstanding == '0) ||
                      ((outstanding == OUT_W'(1)) && wb.ack);

  assign wb.cyc = cyc;
  assign wb.stb = stb;

  always_comb begin
    state_nxt = state;
    cyc       = 1'b0;
    stb       = 1'b0;
    o_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        cyc = 1'b1;
        // Dropped in the same cycle that enable or credit goes away.
        stb = i_enable && credit;
        if (tmo_hit)        state_nxt = ABORT;
        else if (!i_enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        cyc = 1'b1;
        if (tmo_hit)         state_nxt = ABORT;
        else if (drain_done) state_nxt = IDLE;
      end
      ABORT: begin
        o_timeout = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_wb4_mclk) begin
    if (i_wb4_mrst) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge i_wb4_mclk) begin
    if (i_wb4_mrst) begin
      outstanding <= '0;
    end else if (state_nxt == ABORT) begin
      // Requests still in flight at abort are forgotten.
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + OUT_W'(accept) - OUT_W'(ack_ok);
    end
  end

  always_ff @(posedge i_wb4_mclk) begin
    if (i_wb4_mrst) begin
      tmo_cnt <= '0;
    end else if (wb.ack || (outstanding == '0) || !in_cycle) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Response buffer: pointers carry one extra bit so full and empty differ.
  always_ff @(posedge i_wb4_mclk) begin
    if (i_wb4_mrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LVL_W'(1);
      if (pop)  rd_ptr <= rd_ptr + LVL_W'(1);
    end
  end

  always_ff @(posedge i_wb4_mclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wb.data;
  end

  // Storage is not reset, so the head is masked while the buffer is empty.
  assign o_valid = (level != '0);
  assign o_data  = o_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign o_level = level;

  a_no_push_when_full: assert property (
    @(posedge i_wb4_mclk) disable iff (i_wb4_mrst) !(ack_ok && full)
  );

endmodule

// File: tb/tb_wb4_fifo_read_master.sv
module tb_wb4_fifo_read_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic [2:0] o_level;
  logic       o_timeout;

  always #5 clk = ~clk;

  wb4_fifo_read_master_if #(.P_DATA_MSB(7)) wb ();

  wb4_fifo_read_master dut (
    .i_wb4_mclk (clk),
    .i_wb4_mrst (rst),
    .i_enable   (en),
    .wb         (wb),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (rdy),
    .o_level    (o_level),
    .o_timeout  (o_timeout)
  );

  // Slave model: serves src_mem[0..src_n-1], stalls when exhausted, acks
  // accepted strobes in order one cycle later unless ack_hold is set.
  logic       slave_clr = 1'b1;
  logic       ack_hold = 1'b0;
  logic       spur_ack = 1'b0;
  logic [7:0] src_mem [64];
  int         src_n = 0;
  int         src_idx = 0;
  int         pend_wr = 0;
  int         pend_rd = 0;
  logic [7:0] pend_mem [64];
  logic       real_ack;
  logic       acc;

  // Monitor state
  int         cyc_cnt = 0;
  int         acc_cnt = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_mem [64];
  int         max_out = 0;
  int         first_acc = -1;
  int         last_acc = -1;
  int         first_vld = -1;
  int         tmo_seen = 0;
  int         tmo_cyc = -1;
  logic       tmo_cyc_mcyc = 1'b1;

  assign wb.stall = (src_idx >= src_n);
  assign real_ack = !ack_hold && (pend_wr != pend_rd);
  assign wb.ack   = real_ack || spur_ack;
  assign wb.data  = real_ack ? pend_mem[pend_rd[5:0]] : 8'hEE;
  assign acc      = wb.cyc && wb.stb && !wb.stall;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (slave_clr) begin
      src_idx <= 0; pend_wr <= 0; pend_rd <= 0; acc_cnt <= 0; rx_cnt <= 0;
      max_out <= 0; first_acc <= -1; last_acc <= -1; first_vld <= -1;
      tmo_seen <= 0; tmo_cyc <= -1; tmo_cyc_mcyc <= 1'b1;
    end else begin
      if (acc) begin
        pend_mem[pend_wr[5:0]] <= src_mem[src_idx[5:0]];
        pend_wr <= pend_wr + 1;
        src_idx <= src_idx + 1;
        acc_cnt <= acc_cnt + 1;
        if (first_acc < 0) first_acc <= cyc_cnt;
        last_acc <= cyc_cnt;
      end
      if (real_ack) pend_rd <= pend_rd + 1;
      if ((pend_wr - pend_rd) > max_out) max_out <= pend_wr - pend_rd;
      if (o_valid && rdy) begin
        rx_mem[rx_cnt[5:0]] <= o_data;
        rx_cnt <= rx_cnt + 1;
      end
      if (o_valid && first_vld < 0) first_vld <= cyc_cnt;
      if (o_timeout) begin
        tmo_seen <= tmo_seen + 1;
        tmo_cyc <= cyc_cnt;
        tmo_cyc_mcyc <= wb.cyc;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at posedge+1 of the first cycle after reset.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; slave_clr = 1'b1; en = 1'b0; rdy = 1'b0;
    ack_hold = 1'b0; spur_ack = 1'b0; src_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; slave_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"}, wb.cyc, 0);
    check({tag, "_stb"}, wb.stb, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_level"}, o_level, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_timeout"}, o_timeout, 0);
  endtask

  typedef struct {
    logic       en;
    logic       rdy;
    logic       cyc;
    logic       stb;
    logic       vld;
    logic [7:0] dat;
    logic [2:0] lvl;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int bad;

    // Ready held low with 10 words available: credit stops strobes at 4,
    // then ready releases the backlog in order.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h30, 3'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h30, 3'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 3'd3};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 3'd4};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 3'd4};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 3'd4};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h31, 3'd3};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h32, 3'd2};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h34, 3'd2};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h35, 3'd2};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h36, 3'd2};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h37, 3'd2};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h38, 3'd2};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h39, 3'd1};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};

    // Reset state
    do_reset();
    @(negedge clk);
    check_all_zero("reset");

    // Table-driven backpressure sequence
    do_reset();
    for (int k = 0; k < 10; k++) src_mem[k] = 8'h30 + 8'(k);
    src_n = 10;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) tick();
      en = tbl[i].en;
      rdy = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("row%0d_cyc", i), wb.cyc, tbl[i].cyc);
      check($sformatf("row%0d_stb", i), wb.stb, tbl[i].stb);
      check($sformatf("row%0d_valid", i), o_valid, tbl[i].vld);
      check($sformatf("row%0d_data", i), o_data, tbl[i].dat);
      check($sformatf("row%0d_level", i), o_level, tbl[i].lvl);
    end
    check("bp_rx_count", rx_cnt, 10);
    bad = 0;
    for (int k = 0; k < 10; k++) if (rx_mem[k] !== 8'h30 + 8'(k)) bad++;
    check("bp_rx_order_errors", bad, 0);
    check("bp_accepts", acc_cnt, 10);

    // Always-ready slave streaming 0x01..0x10
    do_reset();
    for (int k = 0; k < 16; k++) src_mem[k] = 8'(k + 1);
    src_n = 16; en = 1'b1; rdy = 1'b1;
    for (int t = 0; t < 100 && rx_cnt < 16; t++) @(negedge clk);
    check("stream_rx_count", rx_cnt, 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("stream_word%0d", k), rx_mem[k], 8'(k + 1));
    check("stream_first_latency", first_vld - first_acc, 2);
    check("stream_strobes_back_to_back", last_acc - first_acc, 15);
    check("stream_outstanding_le_4", (max_out <= 4), 1);

    // 20 stalled cycles, then 0xA5 appears
    do_reset();
    en = 1'b1; rdy = 1'b1;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      @(negedge clk);
      if (wb.stb !== 1'b1 || wb.cyc !== 1'b1 || o_timeout !== 1'b0) bad++;
    end
    check("stall_stb_held_errors", bad, 0);
    tick();
    src_mem[0] = 8'hA5; src_n = 1;
    for (int t = 0; t < 20 && rx_cnt < 1; t++) @(negedge clk);
    check("stall_rx_count", rx_cnt, 1);
    check("stall_rx_word", rx_mem[0], 8'hA5);
    check("stall_no_timeout", tmo_seen, 0);

    // Enable drops with 3 outstanding
    do_reset();
    src_mem[0] = 8'h61; src_mem[1] = 8'h62; src_mem[2] = 8'h63;
    src_n = 3; ack_hold = 1'b1; en = 1'b1; rdy = 1'b1;
    for (int t = 0; t < 20 && acc_cnt < 3; t++) @(negedge clk);
    check("drop_accepts", acc_cnt, 3);
    check("drop_stb_before", wb.stb, 1);
    tick(); en = 1'b0;
    @(negedge clk);
    check("drop_stb_now", wb.stb, 0);
    check("drop_cyc_now", wb.cyc, 1);
    tick(); @(negedge clk);
    check("drop_drain_stb", wb.stb, 0);
    check("drop_drain_cyc", wb.cyc, 1);
    tick(); ack_hold = 1'b0; @(negedge clk);
    check("drop_cyc_ack1", wb.cyc, 1);
    tick(); @(negedge clk);
    check("drop_cyc_ack2", wb.cyc, 1);
    tick(); @(negedge clk);
    check("drop_cyc_ack3", wb.cyc, 1);
    tick(); @(negedge clk);
    check("drop_cyc_closed", wb.cyc, 0);
    repeat (3) tick();
    @(negedge clk);
    check("drop_rx_count", rx_cnt, 3);
    check("drop_rx_words", {8'h00, rx_mem[0], rx_mem[1], rx_mem[2]}, 32'h00616263);

    // Two accepts and no ack: timeout abort
    do_reset();
    src_mem[0] = 8'h71; src_mem[1] = 8'h72;
    src_n = 2; ack_hold = 1'b1; en = 1'b1; rdy = 1'b1;
    for (int t = 0; t < 400 && tmo_seen == 0; t++) @(negedge clk);
    check("tmo_pulse_seen", tmo_seen, 1);
    check("tmo_accepts", acc_cnt, 2);
    check("tmo_delay_after_last_accept", tmo_cyc - last_acc, 255);
    check("tmo_mcyc_during_abort", tmo_cyc_mcyc, 0);
    check("tmo_level", o_level, 0);
    tick(); spur_ack = 1'b1;
    @(negedge clk);
    check("tmo_back_active_cyc", wb.cyc, 1);
    tick(); spur_ack = 1'b0;
    @(negedge clk);
    check("tmo_spurious_level", o_level, 0);
    check("tmo_spurious_valid", o_valid, 0);
    check("tmo_single_pulse", tmo_seen, 1);

    // Reset mid-cycle with data buffered and a request in flight
    do_reset();
    for (int k = 0; k < 4; k++) src_mem[k] = 8'h81 + 8'(k);
    src_n = 4; en = 1'b1; rdy = 1'b0;
    repeat (4) tick();
    tick(); rst = 1'b1;
    @(negedge clk);
    check("mrst_level_before", o_level, 3);
    check("mrst_cyc_before", wb.cyc, 1);
    tick(); rst = 1'b0;
    @(negedge clk);
    check_all_zero("mrst_after");
    tick(); @(negedge clk);
    check("mrst_cyc_restart", wb.cyc, 1);
    check("mrst_level_restart", o_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
